// File: rtl/pt8211_sample_sched_if.sv
// Serializer request/data, stream FIFO and beep source signals of the PT8211 sample scheduler.
// Latency: wires only; timing is set by the scheduler that uses the slave modport.
// Backpressure: none here; s_rd and b_ack are one-cycle consume strobes back to the producers.
//
// Signals:
//   drv_req   serializer channel request pulse      drv_data  registered 16-bit sample to serializer
//   ch_right  channel of the last served request    s_empty   stream FIFO empty (FWFT)
//   s_data    FIFO head {L[31:16], R[15:0]}         s_rd      FIFO read strobe
//   b_valid   beep sample available                 b_data    mono beep sample
//   b_ack     beep sample consumed
// master: serializer and producers side. slave: scheduler side.
interface pt8211_sample_sched_if;
  logic        drv_req;
  logic [15:0] drv_data;
  logic        ch_right;
  logic        s_empty;
  logic [31:0] s_data;
  logic        s_rd;
  logic        b_valid;
  logic [15:0] b_data;
  logic        b_ack;

  modport master (
    output drv_req, s_empty, s_data, b_valid, b_data,
    input  drv_data, ch_right, s_rd, b_ack
  );

  modport slave (
    input  drv_req, s_empty, s_data, b_valid, b_data,
    output drv_data, ch_right, s_rd, b_ack
  );
endinterface

// File: rtl/pt8211_sample_sched.sv
// Sample scheduler and stream/beep source arbiter in front of the PT8211 serializer, with volume and mute.
// Latency: drv_data is registered on the drv_req edge and is valid from the next cycle until the next drv_req.
// Backpressure: none; a source is consumed (s_rd / b_ack) only on a left-channel request, at most once per frame.
//
// Ports:
//   clk_1p536m, rst_n      bit clock; asynchronous active-low reset
//   enable                 0 = silence from the next frame start
//   vol                    arithmetic right-shift attenuation, latched at frame start
//   clr_stat               synchronous clear of underrun / underrun_cnt
//   bus                    serializer, stream FIFO and beep signals (slave modport)
//   src                    active source: 0 none, 1 stream, 2 beep
//   underrun, underrun_cnt sticky underrun flag and saturating event count
module pt8211_sample_sched #(
  parameter int VOL_W  = 4,
  parameter int UCNT_W = 16
) (
  input  logic                      clk_1p536m,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [VOL_W-1:0]          vol,
  input  logic                      clr_stat,
  pt8211_sample_sched_if.slave      bus,
  output logic [1:0]                src,
  output logic                      underrun,
  output logic [UCNT_W-1:0]         underrun_cnt
);

  typedef enum logic [1:0] {
    SRC_NONE   = 2'd0,
    SRC_STREAM = 2'd1,
    SRC_BEEP   = 2'd2
  } src_e;

  src_e               src_q, src_d;
  logic               ch_right_q, ch_right_d;
  logic [15:0]        drv_data_q, drv_data_d;
  logic signed [15:0] right_q, right_d;
  logic [VOL_W-1:0]   vol_q, vol_d;
  logic               underrun_q, underrun_d;
  logic [UCNT_W-1:0]  underrun_cnt_q, underrun_cnt_d;

  logic               frame_start;
  logic               underrun_ev;
  logic               s_rd_c;
  logic               b_ack_c;
  logic signed [15:0] left_c;

  // ch_right_q holds the channel just served, so a request while it is 1 is the left half of a new frame.
  assign frame_start = bus.drv_req & ch_right_q;

  always_ff @(posedge clk_1p536m or negedge rst_n) begin
    if (!rst_n) begin
      src_q          <= SRC_NONE;
      ch_right_q     <= 1'b1;
      drv_data_q     <= '0;
      right_q        <= '0;
      vol_q          <= '0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
    end else begin
      src_q          <= src_d;
      ch_right_q     <= ch_right_d;
      drv_data_q     <= drv_data_d;
      right_q        <= right_d;
      vol_q          <= vol_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
    end
  end

  always_comb begin
    src_d       = src_q;
    ch_right_d  = ch_right_q;
    drv_data_d  = drv_data_q;
    right_d     = right_q;
    vol_d       = vol_q;
    underrun_ev = 1'b0;
    s_rd_c      = 1'b0;
    b_ack_c     = 1'b0;
    left_c      = '0;

    if (bus.drv_req) begin
      ch_right_d = ~ch_right_q;
    end

    if (frame_start) begin
      vol_d = vol;
      if (!enable) begin
        src_d = SRC_NONE;
      end else if (bus.b_valid) begin
        src_d = SRC_BEEP;
      end else if (!bus.s_empty) begin
        src_d = SRC_STREAM;
      end else begin
        // Only a stream that ran dry counts; staying idle is not an underrun.
        underrun_ev = (src_q == SRC_STREAM);
        src_d       = SRC_NONE;
      end

      case (src_d)
        SRC_STREAM: begin
          s_rd_c  = 1'b1;
          left_c  = bus.s_data[31:16];
          right_d = bus.s_data[15:0];
        end
        SRC_BEEP: begin
          b_ack_c = 1'b1;
          left_c  = bus.b_data;
          right_d = bus.b_data;
        end
        default: begin
          left_c  = '0;
          right_d = '0;
        end
      endcase
      // The left sample uses the freshly latched shift so both halves of the frame match.
      drv_data_d = left_c >>> vol;
    end else if (bus.drv_req) begin
      drv_data_d = right_q >>> vol_q;
    end
  end

  always_comb begin
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    if (clr_stat) begin
      underrun_d     = 1'b0;
      underrun_cnt_d = '0;
    end else if (underrun_ev) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != {UCNT_W{1'b1}}) begin
        underrun_cnt_d = underrun_cnt_q + 1'b1;
      end
    end
  end

  assign bus.drv_data  = drv_data_q;
  assign bus.ch_right  = ch_right_q;
  assign bus.s_rd      = s_rd_c;
  assign bus.b_ack     = b_ack_c;
  assign src           = src_q;
  assign underrun      = underrun_q;
  assign underrun_cnt  = underrun_cnt_q;

endmodule

// File: doc/pt8211_sample_sched.md
Name: pt8211_sample_sched

Overview:
Sample scheduler and source arbiter that sits in front of the PT8211 DAC serializer, in the clk_1p536m domain.
It answers the serializer's per-channel sample requests and arbitrates between two producers:
- a stereo PCM stream FIFO carrying {L,R} in 32-bit words;
- a mono beep/tone source.
It also applies frame-coherent volume attenuation and mute, and counts stream underruns.

Parameters:
VOL_W, 4, width of attenuation control (arithmetic right shift amount, 0..2^VOL_W-1)
UCNT_W, 16, width of the saturating underrun counter

Ports:
clk_1p536m  input  1  bit clock; all logic on rising edge
rst_n  input  1  reset, asynchronous, active-low
enable  input  1  1 = play; 0 = output silence from the next frame
vol  input  VOL_W  attenuation shift; sampled at frame start only
drv_req  input  1  serializer request pulse, 1 cycle per channel; after reset, 1st = left, then alternating
drv_data  output  16  signed sample to serializer; valid the cycle after drv_req
s_empty  input  1  stream FIFO empty (first-word-fall-through)
s_data  input  32  FIFO head word: [31:16] left, [15:0] right, signed
s_rd  output  1  FIFO read strobe, 1 cycle
b_valid  input  1  beep sample available (level)
b_data  input  16  signed mono beep sample
b_ack  output  1  beep sample consumed, 1 cycle
ch_right  output  1  channel of last served request (0 = left)
src  output  2  active source: 0 none, 1 stream, 2 beep
underrun  output  1  sticky: stream selected but FIFO empty at a frame start
underrun_cnt  output  UCNT_W  saturating underrun count
clr_stat  input  1  synchronous clear of underrun and underrun_cnt

Behaviour:
- Reset values:
  - drv_data=0, s_rd=0, b_ack=0, ch_right=1 (so the first request is left), src=0.
  - underrun=0, underrun_cnt=0.
  - Internal right-sample holding register = 0; latched volume = 0.
- Channel tracking: on each clock with drv_req=1, the channel toggles and ch_right is updated.
- Frame start: drv_req=1 with the left channel selected. Only at frame start are source, volume and reads decided.
- Source FSM, evaluated at frame start (priority order):
  1. enable=0 -> NONE.
  2. b_valid=1 -> BEEP.
  3. s_empty=0 -> STREAM.
  4. Otherwise: if the previous state was STREAM -> NONE with an underrun event; if it was BEEP or NONE -> NONE with no event.
- Source switching happens only at frame boundaries. Source never changes between the left and right requests of a frame.
- Actions at frame start, same edge as drv_req:
  - STREAM: s_rd=1 for that cycle only; the left sample is s_data[31:16]; s_data[15:0] is held for the right request.
  - BEEP: b_ack=1 for that cycle only; b_data is used for left and held for right (mono duplicated).
  - NONE: left and right are both 0; no s_rd, no b_ack.
- Right request: drv_data is the held right sample. No FIFO or beep activity.
- Latency: drv_data is registered on the drv_req edge, so it is valid for the cycle after drv_req. It holds until the next drv_req.
- Attenuation:
  - drv_data = sample >>> vol_latched (sign-preserving).
  - vol is latched at frame start, so L and R always use the same shift.
  - Shift >=15 yields 0 or -1 for the sign.
- Underrun event:
  - Sets underrun.
  - Increments underrun_cnt, saturating at all-ones.
  - clr_stat takes precedence over a simultaneous event.
- At most one s_rd or b_ack per frame. Neither strobe is ever asserted without drv_req in the same cycle.
- s_rd is never asserted while s_empty=1.
- If drv_req arrives when enable has just dropped mid-frame, the right request still outputs the held right sample; silence begins at the next frame.
- Asynchronous reset mid-frame returns everything to reset values. The next drv_req is treated as left.

Test Plan:
- Reset, FIFO holds {0x1234,0xABCD}, vol=0, enable=1, pulse drv_req twice 16 cycles apart -> s_rd once on the first pulse; drv_data=0x1234 then 0xABCD; src=1.
- b_valid=1 with b_data=0x8000 while FIFO is non-empty -> at next frame start src=2, b_ack once, L=R=0x8000, no s_rd.
- vol=2, FIFO word {0x4000,0xFFF0}; vol changed to 0 between L and R -> drv_data 0x1000 then 0xFFFC.
- STREAM active, FIFO drains empty -> next frame L=R=0, src=0, underrun=1, underrun_cnt=1; three more empty frames -> count stays 1 (state already NONE).
- underrun_cnt forced to all-ones, new underrun event -> stays 0xFFFF; clr_stat together with an event -> 0, underrun=0.
- enable=0 asserted between the L and R requests -> R is still the stream value; next frame 0,0 with no s_rd; async reset between L and R -> next drv_req is treated as left (ch_right=0).
